// File: rtl/i2c_pio_in_if.sv
// i2c_pio_in_if
//   Avalon-MM slave bus bundle for the I2C input PIO.
//   Signals:
//     address    [1:0]  word address
//     chipselect        slave select
//     write_n           write strobe, active-low
//     writedata  [31:0] write data
//     readdata   [31:0] read data, combinational in the slave, zero wait states
//   Modports: master (CPU / bus side), slave (the PIO).
interface i2c_pio_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/i2c_pio_in.sv
// i2c_pio_in
//   Avalon-MM input port that reads the I2C bus lines (SCL, SDA, spare status
//   bits) back into the NIOS. Each bit is synchronized, glitch filtered and
//   edge captured; software reads the filtered level and the sticky edge bits.
//
//   Optional feature macro: I2C_PIO_IN_IRQ_EN
//     defined   -> interruptmask register at address 2 and the irq output
//     undefined -> no irq port, address 2 reads 0, software polls edgecapture
//
//   Ports:
//     clk      system clock
//     reset    asynchronous reset, active-high
//     bus      Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//     in_port  raw asynchronous pin inputs, WIDTH bits
//     irq      |(edgecapture & interruptmask) (only with I2C_PIO_IN_IRQ_EN)
//
//   Register map:
//     0  filtered input value (read-only)
//     1  reads 0
//     2  interruptmask (read/write, only with I2C_PIO_IN_IRQ_EN, else reads 0)
//     3  edgecapture (write 1 to clear a bit)
module i2c_pio_in #(
  parameter int WIDTH         = 7,
  parameter int FILTER_CYCLES = 4,
  parameter int EDGE_TYPE     = 2
) (
  input  logic             clk,
  input  logic             reset,
  i2c_pio_in_if.slave      bus,
  input  logic [WIDTH-1:0] in_port
`ifdef I2C_PIO_IN_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam logic [7:0] FILTER_MAX = 8'(FILTER_CYCLES);
  // Long enough to cover the synchronizer plus filter latency, so pins that
  // are already active when reset releases do not show up as edges.
  localparam logic [8:0] SETTLE_INIT = 9'(FILTER_CYCLES + 3);

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;
  logic [WIDTH-1:0] filtered;
  logic [WIDTH-1:0] filtered_d;
  logic [WIDTH-1:0] edgecapture;
  logic [7:0]       filt_cnt [WIDTH];
  logic [8:0]       settle_cnt;

  logic [WIDTH-1:0] edge_event;
  logic [WIDTH-1:0] cap_set;
  logic [WIDTH-1:0] cap_clear;
  logic             wr_capture;

  assign wr_capture = bus.chipselect & ~bus.write_n & (bus.address == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= in_port;
      sync_q2 <= sync_q1;
    end
  end

  // A bit only flips once the synced value has disagreed with it for
  // FILTER_CYCLES samples in a row; any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filtered <= '0;
      for (int i = 0; i < WIDTH; i++) filt_cnt[i] <= '0;
    end else if (FILTER_CYCLES == 0) begin
      filtered <= sync_q2;
      for (int i = 0; i < WIDTH; i++) filt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q2[i] == filtered[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] + 8'd1 == FILTER_MAX) begin
          filtered[i] <= ~filtered[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    edge_event = '0;
    case (EDGE_TYPE)
      0:       edge_event = filtered & ~filtered_d;
      1:       edge_event = ~filtered & filtered_d;
      default: edge_event = filtered ^ filtered_d;
    endcase
  end

  assign cap_set   = (settle_cnt == '0) ? edge_event : '0;
  assign cap_clear = wr_capture ? bus.writedata[WIDTH-1:0] : '0;

  // Clear is applied before set so an event landing on the same edge as a
  // clearing write keeps the bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filtered_d  <= '0;
      edgecapture <= '0;
      settle_cnt  <= SETTLE_INIT;
    end else begin
      filtered_d  <= filtered;
      edgecapture <= (edgecapture & ~cap_clear) | cap_set;
      if (settle_cnt != '0) settle_cnt <= settle_cnt - 9'd1;
    end
  end

`ifdef I2C_PIO_IN_IRQ_EN
  logic [WIDTH-1:0] interruptmask;
  logic             wr_mask;

  assign wr_mask = bus.chipselect & ~bus.write_n & (bus.address == 2'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      interruptmask <= '0;
    end else if (wr_mask) begin
      interruptmask <= bus.writedata[WIDTH-1:0];
    end
  end

  assign irq = |(edgecapture & interruptmask);
`endif

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0: bus.readdata[WIDTH-1:0] = filtered;
`ifdef I2C_PIO_IN_IRQ_EN
      2'd2: bus.readdata[WIDTH-1:0] = interruptmask;
`endif
      2'd3: bus.readdata[WIDTH-1:0] = edgecapture;
      default: ;
    endcase
  end

  // Write data above WIDTH has no register behind it.
  generate
    if (WIDTH < 32) begin : g_wdata_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^bus.writedata[31:WIDTH];
    end
  endgenerate

endmodule
